// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and enable as a Moore decode of the state.
module mc_control_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;
    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_SH2 = 2'b11;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FN   = 2'b10;
    localparam logic [1:0] ALU_IMM  = 2'b11;
    localparam logic [1:0] PC_ALU   = 2'b00;
    localparam logic [1:0] PC_ALUO  = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;
    localparam logic [1:0] PC_REGA  = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEM_ADDR = STATE_W'(2),
        S_MEM_RD   = STATE_W'(3),
        S_MEM_WB   = STATE_W'(4),
        S_MEM_WR   = STATE_W'(5),
        S_R_EXEC   = STATE_W'(6),
        S_R_WB     = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_I_EXEC   = STATE_W'(9),
        S_I_WB     = STATE_W'(10),
        S_JUMP     = STATE_W'(11),
        S_JAL      = STATE_W'(12),
        S_JR       = STATE_W'(13),
        S_ILLEGAL  = STATE_W'(14)
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;

    logic   pc_en_dec;
    logic   mem_read_dec;
    logic   mem_write_dec;
    logic   ir_write_dec;
    logic   reg_write_dec;

    // State register; illegal_op latches on entry to ILLEGAL and clears only on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI,
                    OP_ANDI,
                    OP_ORI,
                    OP_SLTI:  state_d = S_I_EXEC;
                    OP_J:     state_d = S_JUMP;
                    OP_JAL:   state_d = S_JAL;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC:  state_d = S_R_WB;
            S_I_EXEC:  state_d = S_I_WB;
            S_MEM_WB,
            S_R_WB,
            S_I_WB,
            S_BRANCH,
            S_JUMP,
            S_JAL,
            S_JR:      state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; only ir_write/pc_en look at mem_ready/zero/opcode
    always_comb begin
        pc_en_dec     = 1'b0;
        i_or_d        = 1'b0;
        mem_read_dec  = 1'b0;
        mem_write_dec = 1'b0;
        ir_write_dec  = 1'b0;
        reg_write_dec = 1'b0;
        reg_dst       = DST_RT;
        mem_to_reg    = WB_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read_dec = 1'b1;
                alu_src_b    = SRCB_4;
                ir_write_dec = mem_ready;
                pc_en_dec    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_dec = 1'b1;
                i_or_d       = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_dec = 1'b1;
                reg_dst       = DST_RT;
                mem_to_reg    = WB_MEM;
            end
            S_MEM_WR: begin
                mem_write_dec = 1'b1;
                i_or_d        = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FN;
            end
            S_R_WB: begin
                reg_write_dec = 1'b1;
                reg_dst       = DST_RD;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PC_ALUO;
                // opcode[0] separates bne from beq; IR is held through this state
                pc_en_dec = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_IMM;
            end
            S_I_WB: begin
                reg_write_dec = 1'b1;
            end
            S_JUMP: begin
                pc_en_dec = 1'b1;
                pc_source = PC_JMP;
            end
            S_JAL: begin
                pc_en_dec     = 1'b1;
                pc_source     = PC_JMP;
                reg_write_dec = 1'b1;
                reg_dst       = DST_RA;
                mem_to_reg    = WB_PC;
            end
            S_JR: begin
                pc_en_dec = 1'b1;
                pc_source = PC_REGA;
            end
            default: begin
            end
        endcase
    end

    // Enables are suppressed while rst is high so no write lands in the reset cycle
    assign pc_en      = pc_en_dec & ~rst;
    assign mem_read   = mem_read_dec & ~rst;
    assign mem_write  = mem_write_dec & ~rst;
    assign ir_write   = ir_write_dec & ~rst;
    assign reg_write  = reg_write_dec & ~rst;
    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed table-driven bench for mc_control_fsm: per-cycle inputs, expected state
// and expected output bundle, plus a reset-during-writeback sequence.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle order: pc_en,i_or_d,mem_read,mem_write,ir_write,reg_write,
    //               reg_dst,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source,illegal_op
    localparam logic [17:0] O_RST   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_FETCH = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_FWAIT = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_MADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_MRD   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_MWR   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_REXEC = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [17:0] O_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_RWBR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_BRT   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [17:0] O_BRN   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [17:0] O_IEXEC = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b11,2'b00,1'b0};
    localparam logic [17:0] O_IWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [17:0] O_JUMP  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [17:0] O_JAL   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [17:0] O_JR    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b11,1'b0};
    localparam logic [17:0] O_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [17:0] exp);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] est, input logic [17:0] eo);
        logic [17:0] act;
        act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
        checks++;
        if ({state, act} !== {est, eo}) begin
            errors++;
            $display("FAIL %s: got state=%0d out=%05h, want state=%0d out=%05h",
                     nm, state, act, est, eo);
        end
        checks++;
        if (mem_write && reg_write) begin
            errors++;
            $display("FAIL %s excl: got mem_write=1 reg_write=1, want not both", nm);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        rst = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
    endtask

    initial begin
        // Reset with arbitrary inputs; first table row is the second reset cycle
        drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;

        add(1, 6'h00, 6'h20, 0, 1, 4'd0,  O_RST);
        // R-type add
        add(0, 6'h00, 6'h20, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h00, 6'h20, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h00, 6'h20, 0, 1, 4'd6,  O_REXEC);
        add(0, 6'h00, 6'h20, 0, 1, 4'd7,  O_RWB);
        // lw: one fetch wait, two MEM_RD waits
        add(0, 6'h23, 6'h00, 0, 0, 4'd0,  O_FWAIT);
        add(0, 6'h23, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h23, 6'h00, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h23, 6'h00, 0, 1, 4'd2,  O_MADDR);
        add(0, 6'h23, 6'h00, 0, 0, 4'd3,  O_MRD);
        add(0, 6'h23, 6'h00, 0, 0, 4'd3,  O_MRD);
        add(0, 6'h23, 6'h00, 0, 1, 4'd3,  O_MRD);
        add(0, 6'h23, 6'h00, 0, 1, 4'd4,  O_MWB);
        // sw
        add(0, 6'h2B, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h2B, 6'h00, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h2B, 6'h00, 0, 1, 4'd2,  O_MADDR);
        add(0, 6'h2B, 6'h00, 0, 1, 4'd5,  O_MWR);
        // beq taken, then bne not taken, both with zero=1
        add(0, 6'h04, 6'h00, 1, 1, 4'd0,  O_FETCH);
        add(0, 6'h04, 6'h00, 1, 1, 4'd1,  O_DEC);
        add(0, 6'h04, 6'h00, 1, 1, 4'd8,  O_BRT);
        add(0, 6'h05, 6'h00, 1, 1, 4'd0,  O_FETCH);
        add(0, 6'h05, 6'h00, 1, 1, 4'd1,  O_DEC);
        add(0, 6'h05, 6'h00, 1, 1, 4'd8,  O_BRN);
        // addi
        add(0, 6'h08, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h08, 6'h00, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h08, 6'h00, 0, 1, 4'd9,  O_IEXEC);
        add(0, 6'h08, 6'h00, 0, 1, 4'd10, O_IWB);
        // j, jal, jr
        add(0, 6'h02, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h02, 6'h00, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h02, 6'h00, 0, 1, 4'd11, O_JUMP);
        add(0, 6'h03, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h03, 6'h00, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h03, 6'h00, 0, 1, 4'd12, O_JAL);
        add(0, 6'h00, 6'h08, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h00, 6'h08, 0, 1, 4'd1,  O_DEC);
        add(0, 6'h00, 6'h08, 0, 1, 4'd13, O_JR);
        // illegal opcode: sticky for 10 cycles, then reset clears it
        add(0, 6'h3F, 6'h00, 0, 1, 4'd0,  O_FETCH);
        add(0, 6'h3F, 6'h00, 0, 1, 4'd1,  O_DEC);
        for (int k = 0; k < 10; k++) begin
            add(0, 6'h3F, 6'h00, k[0], 1'(k >> 1), 4'd14, O_ILL);
        end
        add(1, 6'h3F, 6'h00, 0, 1, 4'd14, O_ILL);
        add(0, 6'h00, 6'h20, 0, 1, 4'd0,  O_FETCH);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].op, vq[i].fn, vq[i].z, vq[i].rdy);
            @(negedge clk);
            check($sformatf("row%0d", i), vq[i].st, vq[i].exp);
            @(posedge clk);
            #1;
        end

        // Reset arriving in R_WB abandons the instruction without writing
        drive(0, 6'h00, 6'h20, 0, 1);
        @(negedge clk); check("abort_dec", 4'd1, O_DEC);
        @(posedge clk); #1;
        @(negedge clk); check("abort_exec", 4'd6, O_REXEC);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); check("abort_wb_rst", 4'd7, O_RWBR);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check("abort_fetch", 4'd0, O_FETCH);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
